half_ip_sched: RTL and testbench

HALF_IP_SCHED -- requirements
Module: half_ip_sched

---
 rtl/half_ip_sched.sv | 173 +++++++++++++++++
 tb/tb_half_ip_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_ip_sched.sv
// Scheduler that shares one half-pel interpolator between two requesters.
// Round-robin arbitration in IDLE, one-cycle restart pulse (LAUNCH), wait for
// interpolator completion, then hold the captured result until taken.
// Optional feature macro: FME_TIMEOUT_EN (abort WAIT after TIMEOUT cycles).
module half_ip_sched #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IND_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [IND_W-1:0] req0_ind_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [IND_W-1:0] req1_ind_i,
    output logic             req1_ready_o,
    output logic             ip_rst_n_o,
    output logic [IND_W-1:0] ip_ind_o,
    input  logic             ip_done_i,
    input  logic [71:0]      ip_half_i,
    input  logic [31:0]      ip_half_pix_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [71:0]      rsp_half_o,
    output logic [31:0]      rsp_half_pix_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StResp   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [IND_W-1:0] ip_ind_q, ip_ind_d;
    logic             rsp_id_q, rsp_id_d;
    logic [71:0]      rsp_half_q, rsp_half_d;
    logic [31:0]      rsp_half_pix_q, rsp_half_pix_d;
    // Set once ip_done has been seen low after release, so a done level left
    // over from the previous job is never mistaken for completion.
    logic             armed_q, armed_d;

    logic             grant_valid;
    logic             grant_id;

`ifdef FME_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // On contention the requester that did not win last time is granted.
    assign grant_valid = req0_valid_i | req1_valid_i;
    assign grant_id    = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;

    // Next-state, handshake and capture decisions.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        ip_ind_d       = ip_ind_q;
        rsp_id_d       = rsp_id_q;
        rsp_half_d     = rsp_half_q;
        rsp_half_pix_d = rsp_half_pix_q;
        armed_d        = armed_q;
        req0_ready_o   = 1'b0;
        req1_ready_o   = 1'b0;
`ifdef FME_TIMEOUT_EN
        cnt_d          = cnt_q;
        rsp_err_d      = rsp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    req0_ready_o = ~grant_id;
                    req1_ready_o = grant_id;
                    ip_ind_d     = grant_id ? req1_ind_i : req0_ind_i;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = StLaunch;
                end
            end
            StLaunch: begin
                armed_d = ~ip_done_i;
`ifdef FME_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                armed_d = armed_q | ~ip_done_i;
                if (ip_done_i && armed_q) begin
                    rsp_half_d     = ip_half_i;
                    rsp_half_pix_d = ip_half_pix_i;
`ifdef FME_TIMEOUT_EN
                    rsp_err_d      = 1'b0;
`endif
                    state_d        = StResp;
                end
`ifdef FME_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rsp_half_d     = '0;
                    rsp_half_pix_d = '0;
                    rsp_err_d      = 1'b1;
                    state_d        = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            ip_ind_q       <= '0;
            rsp_id_q       <= 1'b0;
            rsp_half_q     <= '0;
            rsp_half_pix_q <= '0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            ip_ind_q       <= ip_ind_d;
            rsp_id_q       <= rsp_id_d;
            rsp_half_q     <= rsp_half_d;
            rsp_half_pix_q <= rsp_half_pix_d;
            armed_q        <= armed_d;
        end
    end

`ifdef FME_TIMEOUT_EN
    // Timeout counter and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign ip_rst_n_o     = (state_q == StWait) || (state_q == StResp);
    assign ip_ind_o       = ip_ind_q;
    assign rsp_valid_o    = (state_q == StResp);
    assign rsp_id_o       = rsp_id_q;
    assign rsp_half_o     = rsp_half_q;
    assign rsp_half_pix_o = rsp_half_pix_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_half_ip_sched.sv
// Self-checking bench for half_ip_sched: directed job table, multi-cycle
// corner sequences, and a randomized run against a job-level reference model.
module tb_half_ip_sched;

    localparam int unsigned IpLat  = 27;
    localparam int unsigned RspLat = 2 + IpLat;
    localparam logic [71:0] Salt72 = 72'h5ac319e72b9044d16f;
    localparam logic [31:0] Salt32 = 32'h13579bdf;

    logic        clk_i, rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic [7:0]  req0_ind_i, req1_ind_i;
    logic        req0_ready_o, req1_ready_o;
    logic        ip_rst_n_o;
    logic [7:0]  ip_ind_o;
    logic        ip_done_i;
    logic [71:0] ip_half_i;
    logic [31:0] ip_half_pix_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o, busy_o;
    logic [71:0] rsp_half_o;
    logic [31:0] rsp_half_pix_o;

    half_ip_sched #(.TIMEOUT(64), .IND_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ind_i(req0_ind_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_ind_i(req1_ind_i), .req1_ready_o(req1_ready_o),
        .ip_rst_n_o(ip_rst_n_o), .ip_ind_o(ip_ind_o), .ip_done_i(ip_done_i),
        .ip_half_i(ip_half_i), .ip_half_pix_i(ip_half_pix_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_half_o(rsp_half_o), .rsp_half_pix_o(rsp_half_pix_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Interpolator model: done rises IpLat cycles after restart is released.
    int unsigned ip_cnt;
    logic        done_model;
    bit          force_hi, force_lo;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                ip_cnt <= 0;
        else if (!ip_rst_n_o)     ip_cnt <= 0;
        else if (ip_cnt < IpLat)  ip_cnt <= ip_cnt + 1;
    end
    assign done_model    = ip_rst_n_o && (ip_cnt >= IpLat - 1);
    assign ip_done_i     = force_hi | (done_model & ~force_lo);
    assign ip_half_i     = {9{ip_ind_o}} ^ Salt72;
    assign ip_half_pix_i = {4{ip_ind_o}} ^ Salt32;

    function automatic logic [71:0] exp_half(input logic [7:0] ind);
        return {9{ind}} ^ Salt72;
    endfunction
    function automatic logic [31:0] exp_pix(input logic [7:0] ind);
        return {4{ind}} ^ Salt32;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One complete job from IDLE; checks grant, latency, response and release.
    task automatic run_job(input bit v0, input bit v1, input logic [7:0] i0,
                           input logic [7:0] i1, input bit er0, input bit er1,
                           input int exp_lat, input bit exp_err, input int bp,
                           input int stale);
        logic [7:0]  ind;
        logic [71:0] eh;
        logic [31:0] ep;
        int          age;
        ind = er1 ? i1 : i0;
        eh  = exp_err ? 72'h0 : exp_half(ind);
        ep  = exp_err ? 32'h0 : exp_pix(ind);
        next_cycle();
        rsp_ready_i  = 1'b0;
        force_hi     = (stale > 0);
        req0_valid_i = v0; req0_ind_i = i0;
        req1_valid_i = v1; req1_ind_i = i1;
        @(negedge clk_i);
        chk("grant", {req0_ready_o, req1_ready_o}, {er0, er1});
        next_cycle();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk_i);
        chk("launch_ind", ip_ind_o, ind);
        chk("launch_rstn", ip_rst_n_o, 1'b0);
        age = 1;
        while (!rsp_valid_o && age < 100) begin
            next_cycle();
            if (age + 1 >= 2 + stale) force_hi = 1'b0;
            @(negedge clk_i);
            age++;
        end
        force_hi = 1'b0;
        chk("latency", age, exp_lat);
        chk("rsp_id", rsp_id_o, er1);
        chk("rsp_half", rsp_half_o, eh);
        chk("rsp_half_pix", rsp_half_pix_o, ep);
        chk("rsp_err", rsp_err_o, exp_err);
        chk("ip_ind_hold", ip_ind_o, ind);
        if (bp > 0) begin
            req0_valid_i = 1'b1; req1_valid_i = 1'b1;
            for (int k = 0; k < bp; k++) begin
                next_cycle();
                @(negedge clk_i);
                chk("bp_valid", rsp_valid_o, 1'b1);
                chk("bp_half", rsp_half_o, eh);
                chk("bp_ready", {req0_ready_o, req1_ready_o}, 2'b00);
                chk("bp_rstn", ip_rst_n_o, 1'b1);
            end
        end
        next_cycle();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp_ready_i  = 1'b1;
        next_cycle();
        rsp_ready_i  = 1'b0;
        @(negedge clk_i);
        chk("post_valid", rsp_valid_o, 1'b0);
        chk("post_busy", busy_o, 1'b0);
    endtask

    typedef struct {
        bit         v0, v1;
        logic [7:0] i0, i1;
        bit         r0, r1;
    } vec_t;

    vec_t vecs[6];

    // Randomized phase reference model state (job level).
    bit         p0, p1, m_busy, m_last, m_id, e_r0, e_r1, e_v;
    logic [7:0] pi0, pi1, m_ind;
    int         m_age, seen;

    initial begin
        vecs[0] = '{v0: 1, v1: 0, i0: 8'h55, i1: 8'haa, r0: 1, r1: 0};
        vecs[1] = '{v0: 1, v1: 1, i0: 8'h11, i1: 8'h22, r0: 0, r1: 1};
        vecs[2] = '{v0: 1, v1: 1, i0: 8'h33, i1: 8'h44, r0: 1, r1: 0};
        vecs[3] = '{v0: 0, v1: 1, i0: 8'h66, i1: 8'h77, r0: 0, r1: 1};
        vecs[4] = '{v0: 1, v1: 1, i0: 8'h88, i1: 8'h99, r0: 1, r1: 0};
        vecs[5] = '{v0: 1, v1: 1, i0: 8'ha1, i1: 8'hb2, r0: 0, r1: 1};

        rst_i = 1'b1; force_hi = 1'b0; force_lo = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_ind_i = 8'h0; req1_ind_i = 8'h0; rsp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rstn", ip_rst_n_o, 1'b0);
        chk("rst_ind", ip_ind_o, 8'h0);
        chk("rst_valid", rsp_valid_o, 1'b0);
        chk("rst_id", rsp_id_o, 1'b0);
        chk("rst_half", rsp_half_o, 72'h0);
        chk("rst_pix", rsp_half_pix_o, 32'h0);
        chk("rst_err", rsp_err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].v0, vecs[v].v1, vecs[v].i0, vecs[v].i1,
                    vecs[v].r0, vecs[v].r1, RspLat, 1'b0, 0, 0);

        // Backpressure: req0 only after last grant 1.
        run_job(1, 0, 8'hc4, 8'h00, 1, 0, RspLat, 1'b0, 10, 0);
        // Stale done held through LAUNCH and 5 WAIT cycles.
        run_job(0, 1, 8'h00, 8'h5e, 0, 1, RspLat, 1'b0, 0, 5);

        // Reset in the middle of WAIT.
        next_cycle();
        req0_valid_i = 1'b1; req0_ind_i = 8'h3c;
        @(negedge clk_i);
        chk("mid_grant", {req0_ready_o, req1_ready_o}, 2'b10);
        next_cycle();
        req0_valid_i = 1'b0;
        repeat (11) next_cycle();
        rst_i = 1'b1;
        #2;
        chk("mid_busy", busy_o, 1'b0);
        chk("mid_rstn", ip_rst_n_o, 1'b0);
        chk("mid_valid", rsp_valid_o, 1'b0);
        chk("mid_ind", ip_ind_o, 8'h0);
        next_cycle();
        rst_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            @(negedge clk_i);
            if (rsp_valid_o) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        run_job(1, 1, 8'h7e, 8'he7, 1, 0, RspLat, 1'b0, 0, 0);

        // Interpolator never completes.
        force_lo = 1'b1;
`ifdef FME_TIMEOUT_EN
        run_job(0, 1, 8'h00, 8'h9d, 0, 1, 2 + 64, 1'b1, 0, 0);
`else
        next_cycle();
        req0_valid_i = 1'b1; req0_ind_i = 8'h9d;
        @(negedge clk_i);
        chk("hang_grant", {req0_ready_o, req1_ready_o}, 2'b10);
        next_cycle();
        req0_valid_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            next_cycle();
            @(negedge clk_i);
            if (rsp_valid_o) seen++;
        end
        chk("hang_busy", busy_o, 1'b1);
        chk("hang_no_rsp", seen, 0);
`endif
        force_lo = 1'b0;
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;

        // Randomized traffic against the job-level model.
        p0 = 0; p1 = 0; m_busy = 0; m_last = 1; m_age = 0;
        pi0 = 8'h0; pi1 = 8'h0; m_id = 0; m_ind = 8'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            if (!p0 && $urandom_range(3) == 0) begin p0 = 1; pi0 = 8'($urandom); end
            if (!p1 && $urandom_range(3) == 0) begin p1 = 1; pi1 = 8'($urandom); end
            req0_valid_i = p0; req0_ind_i = p0 ? pi0 : 8'($urandom);
            req1_valid_i = p1; req1_ind_i = p1 ? pi1 : 8'($urandom);
            rsp_ready_i  = ($urandom_range(2) == 0);
            @(negedge clk_i);
            if (m_busy) m_age++;
            e_r0 = !m_busy && p0 && (!p1 || m_last);
            e_r1 = !m_busy && p1 && (!p0 || !m_last);
            e_v  = m_busy && (m_age >= RspLat);
            chk("rnd_ready", {req0_ready_o, req1_ready_o}, {e_r0, e_r1});
            chk("rnd_valid", rsp_valid_o, e_v);
            if (e_v) begin
                chk("rnd_id", rsp_id_o, m_id);
                chk("rnd_half", rsp_half_o, exp_half(m_ind));
                chk("rnd_pix", rsp_half_pix_o, exp_pix(m_ind));
            end
            if (e_r0 || e_r1) begin
                m_busy = 1; m_age = 0; m_id = e_r1; m_last = e_r1;
                m_ind = e_r1 ? pi1 : pi0;
                if (e_r1) p1 = 0;
                else      p0 = 0;
            end else if (e_v && rsp_ready_i) begin
                m_busy = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
